// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on load, then one PC-2 round key per accepted
// transfer, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched #(
    parameter int NROUNDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic        busy_o,
    output logic [47:0] rkey_o,
    output logic [3:0]  round_o,
    output logic        rkey_valid_o,
    input  logic        rkey_ready_i,
    output logic        last_o
);

    localparam logic [3:0] LAST_STEP = 4'(NROUNDS - 1);

    localparam int PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t      state_q;
    state_t      state_nxt;
    logic [27:0] c_p0;
    logic [27:0] d_p0;
    logic [27:0] c_nxt;
    logic [27:0] d_nxt;
    logic [3:0]  step_p0;
    logic        mode_p0;
    logic [47:0] rkey_p1;
    logic        xfer;
    logic [4:0]  enc_idx;
    logic [4:0]  dec_idx;

    // DES bit n of the key lives at key_i[64-n]; parity bits are never selected.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
        return r;
    endfunction

    // Shift table S[1..16] is 1 at rounds 1, 2, 9 and 16, otherwise 2.
    function automatic logic shift_two(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign xfer    = (state_q == EMIT) && rkey_ready_i;
    assign enc_idx = 5'(step_p0) + 5'd2;
    assign dec_idx = 5'd16 - 5'(step_p0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start_i) state_nxt = LOAD;
            LOAD:    state_nxt = EMIT;
            EMIT:    if (xfer && step_p0 == LAST_STEP) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE);
        rkey_valid_o = (state_q == EMIT);
        last_o       = (state_q == EMIT) && (step_p0 == LAST_STEP);
        round_o      = mode_p0 ? (LAST_STEP - step_p0) : step_p0;
        rkey_o       = rkey_p1;
    end

    // Decrypt starts from C16/D16, which equal C0/D0, so LOAD only rotates when encrypting.
    always_comb begin
        c_nxt = c_p0;
        d_nxt = d_p0;
        if (state_q == LOAD) begin
            if (!mode_p0) begin
                c_nxt = rotl(c_p0, 1'b0);
                d_nxt = rotl(d_p0, 1'b0);
            end
        end else if (state_q == EMIT) begin
            if (mode_p0) begin
                c_nxt = rotr(c_p0, shift_two(dec_idx));
                d_nxt = rotr(d_p0, shift_two(dec_idx));
            end else begin
                c_nxt = rotl(c_p0, shift_two(enc_idx));
                d_nxt = rotl(d_p0, shift_two(enc_idx));
            end
        end
    end

    // Stage p0 holds C/D and the step; stage p1 is the registered round key.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_p0    <= '0;
            d_p0    <= '0;
            step_p0 <= '0;
            mode_p0 <= 1'b0;
            rkey_p1 <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        {c_p0, d_p0} <= pc1(key_i);
                        mode_p0      <= decrypt_i;
                        step_p0      <= '0;
                    end
                end
                LOAD: begin
                    c_p0    <= c_nxt;
                    d_p0    <= d_nxt;
                    rkey_p1 <= pc2({c_nxt, d_nxt});
                end
                EMIT: begin
                    if (xfer && step_p0 != LAST_STEP) begin
                        step_p0 <= step_p0 + 4'd1;
                        c_p0    <= c_nxt;
                        d_p0    <= d_nxt;
                        rkey_p1 <= pc2({c_nxt, d_nxt});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Iterative DES key schedule that sits directly upstream of the DES round datapath.
- Loads a 64-bit key and applies PC-1.
- Streams the sixteen 48-bit round keys (PC-2 outputs), one per accepted transfer, into the Feistel round's rkey input.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) with backpressure, so a sequential round engine can consume keys at its own pace.

Parameters:
- NROUNDS, 16, number of round keys emitted per schedule. Fixed at 16 for DES; present only for bench-side scaling checks.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  load request; accepted only when busy_o=0.
- key_i  input  64  DES key; bit 63 = DES bit 1; parity bits (DES bits 8,16,..,64) ignored.
- decrypt_i  input  1  sampled with start_i; 1 = emit K16..K1.
- busy_o  output  1  schedule in progress.
- rkey_o  output  48  current round key; bit 47 = PC-2 bit 1.
- round_o  output  4  index of the key on rkey_o (0 = K1 .. 15 = K16), true DES index independent of order.
- rkey_valid_o  output  1  rkey_o/round_o valid.
- rkey_ready_i  input  1  consumer accepts the key when rkey_valid_o & rkey_ready_i.
- last_o  output  1  high with the 16th key of the schedule.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE; busy_o=0, rkey_valid_o=0, last_o=0, rkey_o=0, round_o=0; C/D registers cleared; any in-flight schedule is abandoned with no further keys emitted.
- Registers:
  - C[27:0], D[27:0]: PC-1 halves.
  - step counter [3:0].
  - mode bit.
- Shift table S[i] for i=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- State IDLE:
  - On start_i=1: C/D <= PC-1(key_i); mode <= decrypt_i; step <= 0; go to LOAD.
  - start_i while not IDLE is ignored.
- State LOAD (1 cycle) prepares the first key:
  - encrypt: C/D rotate left by S[1].
  - decrypt: no rotation, since C16=C0 and D16=D0.
  - Then go to EMIT with rkey_o <= PC-2(C,D) registered.
  - Latency start_i accept -> first rkey_valid_o = 2 cycles.
- State EMIT:
  - rkey_valid_o=1 and rkey_o is held stable while rkey_ready_i=0 (no change to any output).
  - On transfer with step<15:
    - step++.
    - encrypt: rotate left by S[step+2] (1-based next-round table index).
    - decrypt: rotate right by S[17-(step+1)] (right shifts 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for successive keys).
    - Present the next key on the following cycle.
  - Zero-bubble streaming: with rkey_ready_i held at 1, a new key is presented every cycle. The next key is computed combinationally from the rotated C/D into the output register.
  - On transfer with step=15: go to IDLE; rkey_valid_o, last_o and busy_o drop next cycle.
- round_o:
  - encrypt: = step.
  - decrypt: = 15-step.
- last_o = rkey_valid_o & (step==15).
- busy_o = 1 in LOAD and EMIT.
- Total C/D rotation over a full encrypt schedule is 28, restoring C0/D0; no final rotation is applied after K16.
- start_i asserted in the same cycle as the final transfer is ignored (state still EMIT). A new start is accepted from the first IDLE cycle.
- Reset asserted while rkey_valid_o=1 clears rkey_valid_o on that same edge.

Test Plan:
- Reset, then encrypt start with key_i=0x133457799BBCDFF1, rkey_ready_i=1:
  - first key 2 cycles after start: rkey_o=0x1B02EFFC7072, round_o=0.
  - 16 consecutive valid cycles.
  - final key rkey_o=0xCB3D8B0E17F5, round_o=15, last_o=1.
  - busy_o=0 next cycle.
- Same key, decrypt_i=1: first key 0xCB3D8B0E17F5 with round_o=15; last key 0x1B02EFFC7072 with round_o=0 and last_o=1. The full sequence equals the encrypt sequence reversed.
- Backpressure: random rkey_ready_i (~50%) on the encrypt vector:
  - rkey_o/round_o are stable during every stall cycle.
  - the 16 accepted keys match the reference model exactly.
  - no key is skipped or duplicated.
- Parity independence: key_i=0x133457799BBCDFF1 ^ 0x0101010101010101 yields keys identical to scenario 1.
- Reset mid-schedule: assert rst_i after the 5th transfer:
  - next cycle rkey_valid_o=0, busy_o=0.
  - a subsequent start produces a clean K1=0x1B02EFFC7072.
- Start while busy: pulse start_i with a different key during EMIT, including on the last-transfer cycle. The key stream is unaffected; a start one cycle after busy_o falls is accepted.
